ddr_zqcal_ctrl: RTL and testbench



---
 rtl/ddr_zqcal_pkg.sv | 20 ++
 rtl/ddr_zqcal_vote.sv | 29 ++
 rtl/demet.sv | 24 ++
 rtl/ddr_zqcal_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ddr_zqcal_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ddr_zqcal_pkg.sv
// Shared types and constants for the ZQ calibration sequencer.
package ddr_zqcal_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P_SETTLE = 3'd1,
    P_SAMPLE = 3'd2,
    N_SETTLE = 3'd3,
    N_SAMPLE = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } zqcal_state_t;

  localparam int ZQCAL_SYNC_STAGES = 2;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/ddr_zqcal_vote.sv
// Three-sample history of the synchronized comparator with a 2-of-3 majority
// decision; maj_s reflects the two stored samples plus the current one.
module ddr_zqcal_vote (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic din,
  output logic maj_s
);
  import ddr_zqcal_pkg::*;

  logic [2:0] smp_r;
  logic [2:0] smp_next_s;

  assign smp_next_s = {smp_r[1:0], din};
  assign maj_s      = maj3(smp_next_s);

  // Capture one comparator sample per sampling cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_r <= 3'b000;
    end else if (shift_en) begin
      smp_r <= smp_next_s;
    end else begin
      smp_r <= smp_r;
    end
  end

endmodule

// File: rtl/demet.sv
// Generic multi-flop synchronizer for a single asynchronous bit.
module demet #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/ddr_zqcal_ctrl.sv
// ZQ calibration sequencer: linear PCAL then NCAL search against the analog
// comparator. Optional 2-of-3 sample voting with DDR_ZQCAL_MAJORITY_VOTE_EN.
module ddr_zqcal_ctrl #(
  parameter int CODE_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_settle_cyc,
  input  logic              i_zqcal_comp,
  output logic              o_cal_ena,
  output logic              o_pd_sel,
  output logic [CODE_W-1:0] o_pcal,
  output logic [CODE_W-1:0] o_ncal,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  import ddr_zqcal_pkg::*;

  localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
  localparam logic [CODE_W-1:0] CODE_ZERO = {CODE_W{1'b0}};
  localparam logic [CODE_W-1:0] CODE_ONE  = {{(CODE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  zqcal_state_t     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             comp_s;
  logic             trip_s;
  logic             decide_s;

  demet #(.STAGES(ZQCAL_SYNC_STAGES)) u_demet (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_zqcal_comp),
    .q     (comp_s)
  );

`ifdef DDR_ZQCAL_MAJORITY_VOTE_EN
  logic [1:0] samp_cnt_r;
  logic       sample_s;

  assign sample_s = (state_r == P_SAMPLE) || (state_r == N_SAMPLE);
  assign decide_s = sample_s && (samp_cnt_r == 2'd2);

  ddr_zqcal_vote u_vote (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .shift_en (sample_s),
    .din      (comp_s),
    .maj_s    (trip_s)
  );

  // Count the three cycles of each sampling window
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      samp_cnt_r <= 2'd0;
    end else if (i_abort || !sample_s || decide_s) begin
      samp_cnt_r <= 2'd0;
    end else begin
      samp_cnt_r <= samp_cnt_r + 2'd1;
    end
  end
`else
  assign decide_s = 1'b1;
  assign trip_s   = comp_s;
`endif

  // Calibration sequencer with registered analog controls and status
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      o_cal_ena <= 1'b0;
      o_pd_sel  <= 1'b0;
      o_pcal    <= CODE_ZERO;
      o_ncal    <= CODE_ZERO;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else if (i_abort) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      o_cal_ena <= 1'b0;
      o_pd_sel  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            state_r   <= P_SETTLE;
            cnt_r     <= i_settle_cyc - CNT_ONE;
            o_cal_ena <= 1'b1;
            o_pd_sel  <= 1'b0;
            o_pcal    <= CODE_ZERO;
            o_busy    <= 1'b1;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        P_SETTLE, N_SETTLE: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= (state_r == P_SETTLE) ? P_SAMPLE : N_SAMPLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        P_SAMPLE: begin
          if (!decide_s) begin
            state_r <= state_r;
          end else if (trip_s) begin
            state_r  <= N_SETTLE;
            cnt_r    <= i_settle_cyc - CNT_ONE;
            o_pd_sel <= 1'b1;
            o_ncal   <= CODE_ZERO;
          end else if (o_pcal != CODE_MAX) begin
            state_r <= P_SETTLE;
            cnt_r   <= i_settle_cyc - CNT_ONE;
            o_pcal  <= o_pcal + CODE_ONE;
          end else begin
            state_r   <= ERR;
            o_cal_ena <= 1'b0;
            o_pd_sel  <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b1;
          end
        end
        N_SAMPLE: begin
          if (!decide_s) begin
            state_r <= state_r;
          end else if (trip_s) begin
            state_r   <= DONE;
            o_cal_ena <= 1'b0;
            o_pd_sel  <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
          end else if (o_ncal != CODE_MAX) begin
            state_r <= N_SETTLE;
            cnt_r   <= i_settle_cyc - CNT_ONE;
            o_ncal  <= o_ncal + CODE_ONE;
          end else begin
            state_r   <= ERR;
            o_cal_ena <= 1'b0;
            o_pd_sel  <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= CNT_ZERO;
          o_cal_ena <= 1'b0;
          o_pd_sel  <= 1'b0;
          o_busy    <= 1'b0;
          o_done    <= 1'b0;
          o_err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_zqcal_ctrl.sv
// Randomized self-checking bench for ddr_zqcal_ctrl; expected outputs come from
// a closed-form model of the search (cycle index -> phase, code, status).
module tb_ddr_zqcal_ctrl;

  localparam int CW   = 5;
  localparam int NW   = 8;
  localparam int MAXC = 31;
`ifdef DDR_ZQCAL_MAJORITY_VOTE_EN
  localparam int K    = 3;
  localparam bit VOTE = 1'b1;
`else
  localparam int K    = 1;
  localparam bit VOTE = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [NW-1:0] settle;
  logic          comp;
  logic          cal_ena, pd_sel, busy, done, err;
  logic [CW-1:0] pcal, ncal;
  logic          glitch;
  logic [14:0]   obs;

  int tp, tn;
  int n_checks, n_fail;
  logic [14:0] cur_exp;

  ddr_zqcal_ctrl #(.CODE_W(CW), .CNT_W(NW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_settle_cyc (settle),
    .i_zqcal_comp (comp),
    .o_cal_ena    (cal_ena),
    .o_pd_sel     (pd_sel),
    .o_pcal       (pcal),
    .o_ncal       (ncal),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  // Analog comparator model: trips once the active code reaches its threshold
  assign comp = glitch | (pd_sel ? (int'(ncal) >= tn) : (int'(pcal) >= tp));
  assign obs  = {cal_ena, pd_sel, busy, done, err, pcal, ncal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected {cal_ena,pd_sel,busy,done,err,pcal,ncal} n edges after start accept
  function automatic logic [14:0] model(int n, int tpv, int tnv, int c, logic [4:0] nprev);
    int pe, ne, m;
    pe = (tpv > MAXC) ? MAXC : tpv;
    if (n < (pe + 1) * c) return {5'b10100, 5'(n / c), nprev};
    if (tpv > MAXC) return {5'b00001, 5'(MAXC), nprev};
    m  = n - (tpv + 1) * c;
    ne = (tnv > MAXC) ? MAXC : tnv;
    if (m < (ne + 1) * c) return {5'b11100, 5'(tpv), 5'(m / c)};
    if (tnv > MAXC) return {5'b00001, 5'(tpv), 5'(MAXC)};
    return {5'b00010, 5'(tpv), 5'(tnv)};
  endfunction

  task automatic run_cal(input int tp_i, input int tn_i, input int s, input int abort_at,
                         input bit rand_start);
    int n, c, gap;
    logic [14:0] e;
    logic [4:0] nprev;
    tp = tp_i; tn = tn_i; settle = NW'(s);
    c = s + K; nprev = cur_exp[4:0]; gap = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    forever begin
      e = model(n, tp, tn, c, nprev);
      check("step", 32'(obs), 32'(e));
      cur_exp = e;
      if (n == abort_at) begin
        abort = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        abort = 1'b0; start = 1'b0; glitch = 1'b0;
        check("abort", 32'(obs & 15'h5fff), 32'({5'b00000, e[9:0]}));
        cur_exp = {5'b00000, e[9:0]};
        @(negedge clk);
        check("abort_hold", 32'(obs & 15'h5fff), 32'(cur_exp));
        return;
      end
      if (!e[12]) break;
      if (n > 5000) begin
        check("timeout", 32'(n), 32'(0));
        break;
      end
      start  = rand_start && ($urandom_range(0, 7) == 0);
      glitch = 1'b0;
      gap++;
      if (VOTE && gap > 4 && $urandom_range(0, 3) == 0) begin
        glitch = 1'b1;
        gap = 0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; glitch = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("hold", 32'(obs), 32'(cur_exp));
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; glitch = 1'b0;
    settle = NW'(4); tp = 99; tn = 99; cur_exp = 15'd0;
    #12;
    check("reset", 32'(obs), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle", 32'(obs), 32'(0));

    // Nominal: done after 19 steps of 5 cycles (acceptance edge counted as 1st)
    run_cal(10, 7, 4, -1, 1'b0);
    check("nom_done", 32'({done, err, cal_ena, pcal, ncal}), 32'({3'b100, 5'd10, 5'd7}));

    // Simultaneous start and abort while in DONE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort", 32'(obs), 32'({5'b00000, 5'd10, 5'd7}));
    cur_exp = obs;

    // Saturation: comparator never trips
    run_cal(99, 99, 4, -1, 1'b0);
    check("sat", 32'({err, done, pcal}), 32'({2'b10, 5'd31}));

    // Abort in N_SETTLE (code 1, second settle cycle)
    run_cal(10, 7, 4, 11 * (4 + K) + (4 + K) + 1, 1'b0);

    // Start pulses while busy are ignored
    run_cal(6, 12, 5, -1, 1'b1);

    // Async reset mid P_SETTLE, no clock edge needed
    settle = NW'(6); tp = 5; tn = 5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst", 32'(obs), 32'(model(0, 5, 5, 6 + K, cur_exp[4:0])));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 32'(obs), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cur_exp = 15'd0;

    // Randomized searches
    for (int r = 0; r < 12; r++) begin
      int a;
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 300)) : -1;
      run_cal(int'($urandom_range(0, 35)), int'($urandom_range(0, 35)),
              int'($urandom_range(3, 8)), a, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
